// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one PC-addressed fetch at a time, waits
// LATENCY cycles, then presents the word (or a NOP with error flag) until taken.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd128,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_ins,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       ins_q;
  logic              err_q;
  logic              capture;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_addr;
  logic              rd_ok;
  logic [31:0]       rd_word;

  // The subtraction is only trusted once addr >= BASE_ADDR, so wrapped offsets
  // from addresses below the base never look in range.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Storage is never reset so a preloaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (load_en && addr_ok(load_addr)) begin
      mem[addr_idx(load_addr)] <= load_data;
    end
  end

  // With zero latency the capture happens on the accepting edge, so the live
  // request address is decoded instead of the latched one.
  always_comb begin
    rd_addr = (state_q == IDLE) ? req_addr : addr_q;
    rd_ok   = addr_ok(rd_addr);
    rd_word = mem[addr_idx(rd_addr)];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = LAT;
          if (LAT == 4'd0) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ins_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (capture) begin
        ins_q <= rd_ok ? rd_word : NOP;
        err_q <= ~rd_ok;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_ins   = ins_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder: two instances (LATENCY 2
// and 0) share clock, reset and load port; one is selected per fetch.
module tb_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'd128;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, resp_ready;
  logic [31:0] req_addr;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  logic        rr_a, rv_a, err_a, rr_b, rv_b, err_b;
  logic [31:0] ins_a, ins_b;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_ins;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cur_lat;
  int          last_acc;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && (sel == 1'b0)), .req_ready(rr_a), .req_addr(req_addr),
    .resp_valid(rv_a), .resp_ready(resp_ready && (sel == 1'b0)),
    .resp_ins(ins_a), .resp_err(err_a),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && (sel == 1'b1)), .req_ready(rr_b), .req_addr(req_addr),
    .resp_valid(rv_b), .resp_ready(resp_ready && (sel == 1'b1)),
    .resp_ins(ins_b), .resp_err(err_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  assign req_ready  = sel ? rr_b  : rr_a;
  assign resp_valid = sel ? rv_b  : rv_a;
  assign resp_ins   = sel ? ins_b : ins_a;
  assign resp_err   = sel ? err_b : err_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit valid_addr(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (valid_addr(a)) model[word_of(a)] = d;
  endtask

  task automatic select(input logic s);
    sel     = s;
    cur_lat = s ? 0 : 2;
  endtask

  // coll: write cd to the fetched word on the same edge the read is captured.
  task automatic fetch(input logic [31:0] a, input int hold, input bit coll, input logic [31:0] cd);
    logic [31:0] e_ins;
    logic        e_err;
    int          lat;
    e_err = !valid_addr(a);
    e_ins = e_err ? NOP : model[word_of(a)];
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a;
    if (coll && cur_lat == 0) begin
      load_en = 1'b1; load_addr = a; load_data = cd;
    end
    @(posedge clk); #1;
    last_acc  = cyc;
    req_valid = 1'b0; req_addr = $urandom; load_en = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      if (coll && lat == cur_lat - 1) begin
        load_en = 1'b1; load_addr = a; load_data = cd;
      end
      @(posedge clk); #1;
      load_en = 1'b0; req_addr = $urandom;
      lat++;
    end
    if (coll && valid_addr(a)) model[word_of(a)] = cd;
    check("latency", 32'(lat), 32'(cur_lat));
    check("resp_ins", resp_ins, e_ins);
    check("resp_err", 32'(resp_err), 32'(e_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_ins", resp_ins, e_ins);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic sweep();
    int prev;
    for (int i = 0; i < 11; i++) begin
      fetch(BASE + 32'(4 * i), 0, 1'b0, '0);
      if (i > 0) check("cadence", 32'(last_acc - prev), 32'(cur_lat + 2));
      prev = last_acc;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          pick;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    select(1'b0);
    #1;
    check("rst_ready_a", 32'(rr_a), 32'd1);
    check("rst_valid_a", 32'(rv_a), 32'd0);
    check("rst_ins_a", ins_a, '0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_ready_b", 32'(rr_b), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) load(BASE + 32'(4 * i), $urandom);
    load(32'd128, 32'h0050_0093);
    load(32'd132, 32'h00A0_0113);
    load(BASE + 32'(4 * (DEPTH - 1)), 32'hDEAD_BEEF);
    load(32'd130, 32'hBAD0_0001);
    load(32'd124, 32'hBAD0_0002);
    load(BASE + 32'(4 * DEPTH), 32'hBAD0_0003);

    fetch(32'd128, 4, 1'b0, '0);
    fetch(32'd132, 0, 1'b0, '0);
    fetch(32'd130, 0, 1'b0, '0);
    fetch(32'd127, 0, 1'b0, '0);
    fetch(BASE + 32'(4 * DEPTH), 0, 1'b0, '0);
    fetch(32'hFFFF_FFFC, 0, 1'b0, '0);
    fetch(BASE + 32'(4 * (DEPTH - 1)), 0, 1'b0, '0);

    sweep();
    select(1'b1);
    sweep();
    fetch(32'd136, 1, 1'b1, 32'h2222_2222);
    fetch(32'd136, 0, 1'b0, '0);

    select(1'b0);
    fetch(32'd132, 0, 1'b1, 32'h1111_1111);
    fetch(32'd132, 0, 1'b0, '0);

    req_valid = 1'b1; req_addr = 32'd128;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_ins", resp_ins, '0);
    check("arst_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("dropped", 32'(resp_valid), 32'd0);
    end
    fetch(32'd128, 0, 1'b0, '0);

    for (int n = 0; n < 40; n++) begin
      select(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        load(a, $urandom);
      end
      pick = int'($urandom_range(0, 5));
      case (pick)
        0:       a = $urandom;
        1:       a = BASE + 32'(4 * DEPTH) - 32'($urandom_range(0, 8));
        2:       a = BASE - 32'($urandom_range(0, 4));
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      fetch(a, int'($urandom_range(0, 3)), bit'($urandom_range(0, 4) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
